// File: rtl/cpu_bus_pkg.sv
// Shared constants for the CPU memory-bus blocks: requester IDs, arbiter
// lock-state encodings and the fixed instruction-fetch size.
package cpu_bus_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef logic [1:0] lock_state_t;

  localparam lock_state_t LK_IDLE = 2'd0;
  localparam lock_state_t LK_INST = 2'd1;
  localparam lock_state_t LK_DATA = 2'd2;

  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/resp_order_fifo.sv
// In-order FIFO of 1-bit requester IDs, one entry per accepted request.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module resp_order_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] slots;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is left unreset; count/empty decide validity, so stale
  // slot contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between the inst and data channels, returning
// responses in order. Define ARB_RR_EN for round-robin; default is data-first.
module sram_req_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                inst_sram_req,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DATA_W-1:0]   inst_sram_rdata,

  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [1:0]          data_sram_size,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W/8-1:0] data_sram_wstrb,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DATA_W-1:0]   data_sram_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  lock_state_t state;
  lock_state_t state_nxt;
  logic        grant_src;
  logic        grant_valid;
  logic        can_accept;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_head;
  logic        tie_winner;

`ifdef ARB_RR_EN
  logic last_served;

  assign tie_winner = (last_served == SRC_DATA) ? SRC_INST : SRC_DATA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_served <= SRC_INST;
    else if (push) last_served <= grant_src;
  end
`else
  assign tie_winner = SRC_DATA;
`endif

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    grant_src   = SRC_INST;
    grant_valid = 1'b0;
    case (state)
      LK_INST: begin
        grant_src   = SRC_INST;
        grant_valid = inst_sram_req;
      end
      LK_DATA: begin
        grant_src   = SRC_DATA;
        grant_valid = data_sram_req;
      end
      default: begin
        grant_valid = inst_sram_req || data_sram_req;
        if (inst_sram_req && data_sram_req) grant_src = tie_winner;
        else                                grant_src = data_sram_req ? SRC_DATA : SRC_INST;
      end
    endcase
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop        = mem_data_ok && !fifo_empty && !rst;
  assign can_accept = !fifo_full || pop;
  assign mem_req    = grant_valid && can_accept && !rst;
  assign push       = mem_req && mem_addr_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      LK_IDLE: begin
        if (mem_req && !mem_addr_ok)
          state_nxt = (grant_src == SRC_DATA) ? LK_DATA : LK_INST;
      end
      LK_INST, LK_DATA: begin
        if (push || !grant_valid) state_nxt = LK_IDLE;
      end
      default: state_nxt = LK_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LK_IDLE;
    else     state <= state_nxt;
  end

  assign mem_wr    = (grant_src == SRC_DATA) ? data_sram_wr    : 1'b0;
  assign mem_size  = (grant_src == SRC_DATA) ? data_sram_size  : SIZE_WORD;
  assign mem_addr  = (grant_src == SRC_DATA) ? data_sram_addr  : inst_sram_addr;
  assign mem_wstrb = (grant_src == SRC_DATA) ? data_sram_wstrb : '0;
  assign mem_wdata = (grant_src == SRC_DATA) ? data_sram_wdata : '0;

  assign inst_sram_addr_ok = push && (grant_src == SRC_INST);
  assign data_sram_addr_ok = push && (grant_src == SRC_DATA);

  assign inst_sram_data_ok = pop && (fifo_head == SRC_INST);
  assign data_sram_data_ok = pop && (fifo_head == SRC_DATA);
  assign inst_sram_rdata   = (fifo_head == SRC_INST) ? mem_rdata : '0;
  assign data_sram_rdata   = (fifo_head == SRC_DATA) ? mem_rdata : '0;

  resp_order_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (grant_src),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter in its default (data-first) build
// with OUTSTANDING = 2.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_sram_req = 1'b0;
  logic [31:0] inst_sram_addr = '0;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req = 1'b0;
  logic        data_sram_wr = 1'b0;
  logic [1:0]  data_sram_size = 2'b10;
  logic [31:0] data_sram_addr = '0;
  logic [3:0]  data_sram_wstrb = '0;
  logic [31:0] data_sram_wdata = '0;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_req           (mem_req),
    .mem_wr            (mem_wr),
    .mem_size          (mem_size),
    .mem_addr          (mem_addr),
    .mem_wstrb         (mem_wstrb),
    .mem_wdata         (mem_wdata),
    .mem_addr_ok       (mem_addr_ok),
    .mem_data_ok       (mem_data_ok),
    .mem_rdata         (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_sram_req   = 1'b0;
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'b10;
    data_sram_wstrb = '0;
    data_sram_wdata = '0;
    mem_addr_ok     = 1'b0;
    mem_data_ok     = 1'b0;
    mem_rdata       = '0;
  endtask

  bit model_q[$];
  bit pattern [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    // Reset: outputs held low even with requests and a stray data_ok.
    inst_sram_req = 1'b1;
    data_sram_req = 1'b1;
    mem_addr_ok   = 1'b1;
    mem_data_ok   = 1'b1;
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
    check("rst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    next_cycle();

    // Tie with immediate addr_ok: data wins, then inst.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h100;
    data_sram_req = 1'b1; data_sram_addr = 32'h200;
    mem_addr_ok   = 1'b1;
    #1;
    check("tie_mem_req", mem_req, 1);
    check("tie_mem_addr", mem_addr, 32'h200);
    check("tie_data_aok", data_sram_addr_ok, 1);
    check("tie_inst_aok", inst_sram_addr_ok, 0);
    next_cycle();
    data_sram_req = 1'b0;
    #1;
    check("t1_inst_addr", mem_addr, 32'h100);
    check("t1_inst_aok", inst_sram_addr_ok, 1);
    check("t1_inst_size", mem_size, 2'b10);
    check("t1_inst_wr", mem_wr, 0);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'hAAAA;
    #1;
    check("t1_rsp0_data", data_sram_data_ok, 1);
    check("t1_rsp0_inst", inst_sram_data_ok, 0);
    check("t1_rsp0_rdata", data_sram_rdata, 32'hAAAA);
    next_cycle();
    mem_rdata = 32'hBBBB;
    #1;
    check("t1_rsp1_inst", inst_sram_data_ok, 1);
    check("t1_rsp1_data", data_sram_data_ok, 0);
    check("t1_rsp1_rdata", inst_sram_rdata, 32'hBBBB);
    next_cycle();
    clear_inputs();

    // Lock: inst waits 3 cycles for addr_ok while data arrives.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h300;
    #1;
    check("lk_c1_addr", mem_addr, 32'h300);
    next_cycle();
    data_sram_req = 1'b1; data_sram_addr = 32'h400; data_sram_wr = 1'b1;
    #1;
    check("lk_c2_addr", mem_addr, 32'h300);
    check("lk_c2_wr", mem_wr, 0);
    check("lk_c2_daok", data_sram_addr_ok, 0);
    next_cycle();
    #1;
    check("lk_c3_addr", mem_addr, 32'h300);
    next_cycle();
    mem_addr_ok = 1'b1;
    #1;
    check("lk_c4_addr", mem_addr, 32'h300);
    check("lk_c4_iaok", inst_sram_addr_ok, 1);
    check("lk_c4_daok", data_sram_addr_ok, 0);
    next_cycle();
    inst_sram_req = 1'b0;
    #1;
    check("lk_c5_addr", mem_addr, 32'h400);
    check("lk_c5_wr", mem_wr, 1);
    check("lk_c5_daok", data_sram_addr_ok, 1);
    next_cycle();

    // FIFO holds [inst, data]: full, so no request goes out.
    #1;
    check("full_mem_req", mem_req, 0);
    check("full_daok", data_sram_addr_ok, 0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h1234;
    #1;
    check("full_pop_iok", inst_sram_data_ok, 1);
    check("full_pop_rdata", inst_sram_rdata, 32'h1234);
    check("full_pop_req", mem_req, 1);
    check("full_pop_daok", data_sram_addr_ok, 1);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1;
    #1;
    check("drain0_dok", data_sram_data_ok, 1);
    next_cycle();
    #1;
    check("drain1_dok", data_sram_data_ok, 1);
    check("drain1_iok", inst_sram_data_ok, 0);
    next_cycle();
    clear_inputs();

    // Partial write then inst read, responses in issue order.
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'b01;
    data_sram_addr = 32'h500; data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hDEADBEEF;
    mem_addr_ok = 1'b1;
    #1;
    check("wr_wstrb", mem_wstrb, 4'b0011);
    check("wr_wdata", mem_wdata, 32'hDEADBEEF);
    check("wr_size", mem_size, 2'b01);
    check("wr_wr", mem_wr, 1);
    next_cycle();
    data_sram_req = 1'b0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h600;
    #1;
    check("rd_wstrb", mem_wstrb, 0);
    check("rd_wr", mem_wr, 0);
    check("rd_addr", mem_addr, 32'h600);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1;
    #1;
    check("wr_rsp_dok", data_sram_data_ok, 1);
    check("wr_rsp_iok", inst_sram_data_ok, 0);
    next_cycle();
    #1;
    check("rd_rsp_iok", inst_sram_data_ok, 1);
    check("rd_rsp_dok", data_sram_data_ok, 0);
    next_cycle();
    clear_inputs();

    // Reset with two requests outstanding.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h700; mem_addr_ok = 1'b1;
    next_cycle();
    inst_sram_req = 1'b0; data_sram_req = 1'b1; data_sram_addr = 32'h800;
    next_cycle();
    clear_inputs();
    rst = 1'b1;
    #1;
    check("mid_rst_req", mem_req, 0);
    #2;
    rst = 1'b0;
    next_cycle();
    mem_data_ok = 1'b1;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h900;
    #1;
    check("stray_iok", inst_sram_data_ok, 0);
    check("stray_dok", data_sram_data_ok, 0);
    check("post_rst_req", mem_req, 1);
    check("post_rst_addr", mem_addr, 32'h900);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1;
    #1;
    check("post_rst_none", {inst_sram_data_ok, data_sram_data_ok}, 0);
    next_cycle();
    clear_inputs();

    // Fill the FIFO, then 6 back-to-back push+pop cycles while full.
    mem_addr_ok = 1'b1;
    inst_sram_req = 1'b1; inst_sram_addr = 32'hA00;
    model_q.push_back(1'b0);
    next_cycle();
    inst_sram_req = 1'b0; data_sram_req = 1'b1; data_sram_addr = 32'hA04;
    model_q.push_back(1'b1);
    next_cycle();
    data_sram_req = 1'b1;
    mem_addr_ok = 1'b0;
    #1;
    check("bb_full_req", mem_req, 0);
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      bit exp_src;
      inst_sram_req = (pattern[i] == 1'b0);
      data_sram_req = (pattern[i] == 1'b1);
      inst_sram_addr = 32'hB00 + 32'(i);
      data_sram_addr = 32'hC00 + 32'(i);
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      mem_rdata = 32'h5000 + 32'(i);
      exp_src = model_q.pop_front();
      model_q.push_back(pattern[i]);
      #1;
      check($sformatf("bb%0d_req", i), mem_req, 1);
      check($sformatf("bb%0d_iok", i), inst_sram_data_ok, (exp_src == 1'b0));
      check($sformatf("bb%0d_dok", i), data_sram_data_ok, (exp_src == 1'b1));
      next_cycle();
    end
    clear_inputs();
    data_sram_req = 1'b1;
    #1;
    check("bb_still_full", mem_req, 0);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bit exp_src;
      exp_src = model_q.pop_front();
      #1;
      check($sformatf("bb_drain%0d_iok", i), inst_sram_data_ok, (exp_src == 1'b0));
      check($sformatf("bb_drain%0d_dok", i), data_sram_data_ok, (exp_src == 1'b1));
      next_cycle();
    end
    #1;
    check("bb_empty", {inst_sram_data_ok, data_sram_data_ok}, 0);
    clear_inputs();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
